// File: rtl/mesh_eoc_collector.sv
// rtl/mesh_eoc_collector.sv - gathers per-tile end-of-computation reports into one global EOC
// First report per tile wins; a per-run cycle limit can end the run early with an all-ones exit code.
module mesh_eoc_collector #(
  parameter int N_TILES = 4,
  parameter int EXIT_W  = 32,
  parameter int TMO_W   = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [TMO_W-1:0]          timeout_cycles_i,
  input  logic [N_TILES-1:0]        tile_eoc_i,
  input  logic [N_TILES*EXIT_W-1:0] tile_exit_code_i,
  output logic                      busy_o,
  output logic                      eoc_o,
  output logic [EXIT_W-1:0]         exit_code_o,
  output logic                      timeout_o,
  output logic [N_TILES-1:0]        tiles_done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [N_TILES-1:0]        tiles_done_q, tiles_done_d;
  logic [N_TILES*EXIT_W-1:0] codes_q, codes_d;
  logic [TMO_W-1:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]          limit_q, limit_d;
  logic [EXIT_W-1:0]         exit_code_q, exit_code_d;
  logic                      timeout_q, timeout_d;

  logic [N_TILES-1:0]        capture;
  logic [N_TILES*EXIT_W-1:0] merged_codes;
  logic [EXIT_W-1:0]         first_nonzero;
  logic [TMO_W-1:0]          cnt_inc;
  logic                      all_done;
  logic                      tmo_hit;

  // Codes as they will stand after this cycle's captures, so completion can report them immediately.
  always_comb begin
    capture      = tile_eoc_i & ~tiles_done_q;
    merged_codes = codes_q;
    for (int t = 0; t < N_TILES; t++) begin
      if (capture[t]) begin
        merged_codes[t*EXIT_W +: EXIT_W] = tile_exit_code_i[t*EXIT_W +: EXIT_W];
      end
    end
    first_nonzero = '0;
    for (int t = N_TILES - 1; t >= 0; t--) begin
      if (merged_codes[t*EXIT_W +: EXIT_W] != '0) begin
        first_nonzero = merged_codes[t*EXIT_W +: EXIT_W];
      end
    end
    all_done = &(tiles_done_q | capture);
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
    tmo_hit  = (limit_q != '0) && (cnt_inc >= limit_q);
  end

  always_comb begin
    state_d      = state_q;
    tiles_done_d = tiles_done_q;
    codes_d      = codes_q;
    cnt_d        = cnt_q;
    limit_d      = limit_q;
    exit_code_d  = exit_code_q;
    timeout_d    = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          tiles_done_d = '0;
          codes_d      = '0;
          cnt_d        = '0;
          limit_d      = timeout_cycles_i;
          exit_code_d  = '0;
          timeout_d    = 1'b0;
        end
      end
      ST_RUN: begin
        tiles_done_d = tiles_done_q | capture;
        codes_d      = merged_codes;
        cnt_d        = cnt_inc;
        // Completion takes precedence over a timeout landing on the same edge.
        if (all_done) begin
          state_d     = ST_DONE;
          exit_code_d = first_nonzero;
        end else if (tmo_hit) begin
          state_d     = ST_DONE;
          exit_code_d = '1;
          timeout_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      tiles_done_q <= '0;
      codes_q      <= '0;
      cnt_q        <= '0;
      limit_q      <= '0;
      exit_code_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tiles_done_q <= tiles_done_d;
      codes_q      <= codes_d;
      cnt_q        <= cnt_d;
      limit_q      <= limit_d;
      exit_code_q  <= exit_code_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy_o       = (state_q == ST_RUN);
  assign eoc_o        = (state_q == ST_DONE);
  assign exit_code_o  = exit_code_q;
  assign timeout_o    = timeout_q;
  assign tiles_done_o = tiles_done_q;

endmodule

// File: tb/tb_mesh_eoc_collector.sv
// tb/tb_mesh_eoc_collector.sv - directed bench for mesh_eoc_collector
module tb_mesh_eoc_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  tmo;
  logic [3:0]   teoc;
  logic [127:0] tcode;
  logic         busy, eoc, tout;
  logic [31:0]  exitc;
  logic [3:0]   tdone;

  logic         start1;
  logic [0:0]   teoc1;
  logic [31:0]  tcode1;
  logic         busy1, eoc1, tout1;
  logic [31:0]  exitc1;
  logic [0:0]   tdone1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mesh_eoc_collector dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .timeout_cycles_i(tmo),
    .tile_eoc_i(teoc), .tile_exit_code_i(tcode), .busy_o(busy), .eoc_o(eoc),
    .exit_code_o(exitc), .timeout_o(tout), .tiles_done_o(tdone)
  );

  mesh_eoc_collector #(.N_TILES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .timeout_cycles_i(32'd0),
    .tile_eoc_i(teoc1), .tile_exit_code_i(tcode1), .busy_o(busy1), .eoc_o(eoc1),
    .exit_code_o(exitc1), .timeout_o(tout1), .tiles_done_o(tdone1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; tmo = 32'd0; teoc = 4'hF; tcode = '1;
    start1 = 1'b1; teoc1 = 1'b1; tcode1 = 32'h1;
    step(); step();
    n_cmp++; if ({busy, eoc, tout} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {busy, eoc, tout}); end
    n_cmp++; if (exitc !== 32'd0) begin n_fail++; $display("FAIL rst_exit got %h exp 0", exitc); end
    n_cmp++; if (tdone !== 4'h0) begin n_fail++; $display("FAIL rst_tdone got %h exp 0", tdone); end
    n_cmp++; if ({busy1, eoc1, tout1, tdone1} !== 4'b0000) begin n_fail++; $display("FAIL rst_dut1 got %b exp 0000", {busy1, eoc1, tout1, tdone1}); end
    rst_n = 1'b1; start = 1'b0; start1 = 1'b0; teoc1 = 1'b0;
    step();
    n_cmp++; if ({busy, eoc, tdone} !== 6'b0) begin n_fail++; $display("FAIL idle_eoc_ignored got %b exp 0", {busy, eoc, tdone}); end
    teoc = 4'h0; tcode = '0;
  endtask

  task automatic test_staggered();
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if ({busy, eoc} !== 2'b10) begin n_fail++; $display("FAIL stag_start got %b exp 10", {busy, eoc}); end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      teoc = (cyc == 3) ? 4'b0001 : (cyc == 5) ? 4'b0010 : (cyc == 7) ? 4'b0100 : (cyc == 9) ? 4'b1000 : 4'b0000;
      step();
      teoc = 4'h0;
      if (cyc == 8) begin
        n_cmp++; if ({eoc, tdone} !== 5'b0_0111) begin n_fail++; $display("FAIL stag_cyc9 got %b exp 00111", {eoc, tdone}); end
      end
    end
    n_cmp++; if ({busy, eoc, tout} !== 3'b010) begin n_fail++; $display("FAIL stag_done got %b exp 010", {busy, eoc, tout}); end
    n_cmp++; if (exitc !== 32'd0 || tdone !== 4'hF) begin n_fail++; $display("FAIL stag_result got %h/%h exp 0/f", exitc, tdone); end
  endtask

  task automatic test_same_cycle();
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if ({busy, eoc, tdone} !== 6'b10_0000) begin n_fail++; $display("FAIL restart got %b exp 100000", {busy, eoc, tdone}); end
    teoc = 4'hF; tcode = {32'h22, 32'h0, 32'h11, 32'h0};
    step();
    n_cmp++; if ({eoc, tout, tdone} !== 6'b10_1111) begin n_fail++; $display("FAIL same_done got %b exp 101111", {eoc, tout, tdone}); end
    n_cmp++; if (exitc !== 32'h11) begin n_fail++; $display("FAIL same_exit got %h exp 11", exitc); end
    tcode = {32'h1, 32'h2, 32'h3, 32'h4};
    step(); step();
    n_cmp++; if ({eoc, exitc, tdone} !== {1'b1, 32'h11, 4'hF}) begin n_fail++; $display("FAIL done_hold got %b/%h exp 1/11", eoc, exitc); end
    teoc = 4'h0; tcode = '0;
  endtask

  task automatic test_first_capture();
    start = 1'b1; step(); start = 1'b0;
    teoc = 4'b0001; step();
    start = 1'b1; teoc = 4'b0100; tcode = {32'h0, 32'h5, 32'h0, 32'h0};
    step(); start = 1'b0;
    n_cmp++; if ({busy, tdone} !== 5'b1_0101) begin n_fail++; $display("FAIL run_start_ignored got %b exp 10101", {busy, tdone}); end
    tcode = {32'h0, 32'h7, 32'h0, 32'h0};
    step();
    teoc = 4'b0110; step();
    teoc = 4'b1100; step();
    teoc = 4'h0; tcode = '0;
    n_cmp++; if ({eoc, tdone} !== 5'b1_1111) begin n_fail++; $display("FAIL level_done got %b exp 11111", {eoc, tdone}); end
    n_cmp++; if (exitc !== 32'h5) begin n_fail++; $display("FAIL first_capture got %h exp 5", exitc); end
  endtask

  task automatic test_timeout();
    tmo = 32'd20; start = 1'b1; step(); start = 1'b0; tmo = 32'd3;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      teoc = (cyc == 2) ? 4'b0001 : (cyc == 3) ? 4'b0010 : 4'b0000;
      step();
      if (cyc == 19) begin
        n_cmp++; if ({busy, eoc} !== 2'b10) begin n_fail++; $display("FAIL tmo_early got %b exp 10", {busy, eoc}); end
      end
    end
    teoc = 4'h0;
    n_cmp++; if ({busy, eoc, tout} !== 3'b011) begin n_fail++; $display("FAIL tmo_flags got %b exp 011", {busy, eoc, tout}); end
    n_cmp++; if (exitc !== 32'hFFFF_FFFF || tdone !== 4'b0011) begin n_fail++; $display("FAIL tmo_result got %h/%b exp ffffffff/0011", exitc, tdone); end
    tmo = 32'd0;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; step(); start = 1'b0;
    teoc = 4'b0011; step(); teoc = 4'h0;
    n_cmp++; if ({busy, tdone} !== 5'b1_0011) begin n_fail++; $display("FAIL mid_two got %b exp 10011", {busy, tdone}); end
    rst_n = 1'b0; start = 1'b1; teoc = 4'hF; tcode = '1;
    step(); step();
    n_cmp++; if ({busy, eoc, tout, exitc, tdone} !== 39'd0) begin n_fail++; $display("FAIL mid_reset got %b/%h/%b exp all 0", {busy, eoc, tout}, exitc, tdone); end
    rst_n = 1'b1; start = 1'b0; teoc = 4'h0; tcode = '0;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %b exp 0", busy); end
    start = 1'b1; step(); start = 1'b0;
    teoc = 4'hF; step(); teoc = 4'h0;
    n_cmp++; if ({eoc, tout, exitc, tdone} !== {1'b1, 1'b0, 32'd0, 4'hF}) begin n_fail++; $display("FAIL rerun got %b/%h/%b exp 10/0/1111", {eoc, tout}, exitc, tdone); end
  endtask

  task automatic test_tie();
    tmo = 32'd5; start = 1'b1; step(); start = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      teoc  = (cyc == 2) ? 4'b0011 : (cyc == 5) ? 4'b1100 : 4'b0000;
      tcode = (cyc == 5) ? {32'h44, 32'h33, 32'h0, 32'h0} : '0;
      step();
    end
    teoc = 4'h0; tcode = '0;
    n_cmp++; if ({eoc, tout} !== 2'b10) begin n_fail++; $display("FAIL tie_flags got %b exp 10", {eoc, tout}); end
    n_cmp++; if (exitc !== 32'h33) begin n_fail++; $display("FAIL tie_exit got %h exp 33", exitc); end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if ({busy, eoc, tout, tdone} !== 7'b100_0000) begin n_fail++; $display("FAIL done_restart got %b exp 1000000", {busy, eoc, tout, tdone}); end
    tmo = 32'd0;
  endtask

  task automatic test_single_tile();
    start1 = 1'b1; step(); start1 = 1'b0;
    step();
    n_cmp++; if ({busy1, eoc1} !== 2'b10) begin n_fail++; $display("FAIL one_run got %b exp 10", {busy1, eoc1}); end
    teoc1 = 1'b1; tcode1 = 32'h9; step(); teoc1 = 1'b0; tcode1 = 32'h0;
    n_cmp++; if ({busy1, eoc1, tout1, tdone1} !== 4'b0101 || exitc1 !== 32'h9) begin n_fail++; $display("FAIL one_done got %b/%h exp 0101/9", {busy1, eoc1, tout1, tdone1}, exitc1); end
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_same_cycle();
    test_first_capture();
    test_timeout();
    test_reset_mid_run();
    test_tie();
    test_single_tile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
